// File: rtl/phantom_rtc_gate.sv
// rtl/phantom_rtc_gate.sv - phantom clock unlock sequencer and ROM/RAM select gate
// Detects the 64-bit write key, then owns 64 accesses as a serial time transfer.
module phantom_rtc_gate #(
  parameter logic [63:0] KEY    = 64'h5CA33AC55CA33AC5,
  parameter int          TOUT_W = 20
) (
  input  logic        C7M,
  input  logic        nRES,
  input  logic        AccStb,
  input  logic        AccWR,
  input  logic        BitIn,
  input  logic [63:0] TimeIn,
  output logic        RomGate,
  output logic        RTCDOE,
  output logic        RTCBit,
  output logic        TimeWr,
  output logic [63:0] TimeOut
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MATCH = 2'd1,
    S_XFER  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [6:0]        kc_q, kc_d;
  logic [5:0]        xc_q, xc_d;
  logic              wr_seen_q, wr_seen_d;
  logic [63:0]       sr_q, sr_d;
  logic [TOUT_W-1:0] tout_q, tout_d;

  logic key_bit;
  logic key_hit;
  logic key_restart;
  logic tout_expired;
  logic [TOUT_W-1:0] tout_inc;

  assign key_bit      = KEY[kc_q[5:0]];
  assign key_hit      = AccWR & (BitIn == key_bit);
  assign key_restart  = AccWR & (BitIn == KEY[0]);
  assign tout_expired = (&tout_q) & ~AccStb;
  assign tout_inc     = tout_q + {{(TOUT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      state_q   <= S_IDLE;
      kc_q      <= 7'd0;
      xc_q      <= 6'd0;
      wr_seen_q <= 1'b0;
      sr_q      <= 64'd0;
      tout_q    <= '0;
    end else begin
      state_q   <= state_d;
      kc_q      <= kc_d;
      xc_q      <= xc_d;
      wr_seen_q <= wr_seen_d;
      sr_q      <= sr_d;
      tout_q    <= tout_d;
    end
  end

  // tout defaults to clear; only idle cycles in MATCH/XFER let it advance.
  always_comb begin
    state_d   = state_q;
    kc_d      = kc_q;
    xc_d      = xc_q;
    wr_seen_d = wr_seen_q;
    sr_d      = sr_q;
    tout_d    = '0;
    case (state_q)
      S_IDLE, S_MATCH: begin
        if (AccStb) begin
          if (key_hit) begin
            if (kc_q == 7'd63) begin
              state_d   = S_XFER;
              kc_d      = 7'd64;
              sr_d      = TimeIn;
              xc_d      = 6'd0;
              wr_seen_d = 1'b0;
            end else begin
              state_d = S_MATCH;
              kc_d    = kc_q + 7'd1;
            end
          end else if (key_restart) begin
            state_d = S_MATCH;
            kc_d    = 7'd1;
          end else begin
            state_d = S_IDLE;
            kc_d    = 7'd0;
          end
        end else if (state_q == S_MATCH) begin
          if (tout_expired) begin
            state_d = S_IDLE;
            kc_d    = 7'd0;
          end else begin
            tout_d = tout_inc;
          end
        end
      end
      S_XFER: begin
        if (AccStb) begin
          if (AccWR) begin
            sr_d[xc_q] = BitIn;
            wr_seen_d  = 1'b1;
          end
          xc_d = xc_q + 6'd1;
          // The wrap of xc closes the transfer; any write makes it a time update.
          if (xc_q == 6'd63) begin
            state_d = (wr_seen_q | AccWR) ? S_DONE : S_IDLE;
            kc_d    = 7'd0;
          end
        end else if (tout_expired) begin
          state_d = S_IDLE;
          kc_d    = 7'd0;
        end else begin
          tout_d = tout_inc;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        kc_d    = 7'd0;
      end
      default: begin
        state_d = S_IDLE;
        kc_d    = 7'd0;
      end
    endcase
  end

  assign RomGate = (state_q != S_XFER);
  assign RTCDOE  = (state_q == S_XFER) & ~AccWR;
  assign RTCBit  = (state_q == S_XFER) & sr_q[xc_q];
  assign TimeWr  = (state_q == S_DONE);
  assign TimeOut = sr_q;

endmodule
